// File: rtl/map_pkg.sv
// Shared definitions for the MAP core front end: address width and the
// next-PC source encoding used by the sequencer's priority mux.
package map_pkg;

    localparam int MAP_ADDR_W = 8;

    localparam logic [2:0] PCSEL_HOLD = 3'd0;
    localparam logic [2:0] PCSEL_INC  = 3'd1;
    localparam logic [2:0] PCSEL_BR   = 3'd2;
    localparam logic [2:0] PCSEL_JMP  = 3'd3;
    localparam logic [2:0] PCSEL_CALL = 3'd4;
    localparam logic [2:0] PCSEL_RET  = 3'd5;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decode stage (master) and the PC
// sequencer (slave): flow requests in, PC and stack status out.
interface pc_sequencer_if
    import map_pkg::*;
#(
    parameter int ADDR_W      = MAP_ADDR_W,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic              stall;
    logic              branch_en;
    logic [ADDR_W-1:0] offset;
    logic              jump_en;
    logic              call_en;
    logic              ret_en;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic              stack_ovf;
    logic              stack_unf;

    modport master (
        output stall, branch_en, offset, jump_en, call_en, ret_en, target,
        input  pc, sp, stack_ovf, stack_unf
    );

    modport slave (
        input  stall, branch_en, offset, jump_en, call_en, ret_en, target,
        output pc, sp, stack_ovf, stack_unf
    );

endinterface

// File: rtl/pc_stack.sv
// Return-address LIFO. Pushing when full or popping when empty is silently
// dropped; the caller decides whether that is an error.
module pc_stack
    import map_pkg::*;
#(
    parameter int ADDR_W = MAP_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              din,
    output logic [ADDR_W-1:0]              dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [CW-1:0]     countMinus1;
    logic [IW-1:0]     wrIdx;
    logic [IW-1:0]     topIdx;
    logic              doPush;
    logic              doPop;

    // count never exceeds DEPTH-1 while a write is possible, so the low bits index safely
    assign countMinus1 = count_q - CW'(1);
    assign wrIdx       = count_q[IW-1:0];
    assign topIdx      = countMinus1[IW-1:0];

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty && !push;

    always_comb begin
        count_d = count_q;
        if (doPush) begin
            count_d = count_q + CW'(1);
        end else if (doPop) begin
            count_d = countMinus1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && doPush) begin
            mem_q[wrIdx] <= din;
        end
    end

    assign dout  = mem_q[topIdx];
    assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: one-cycle priority selection between increment,
// branch, jump, call and return, with sticky stack overflow/underflow flags.
module pc_sequencer
    import map_pkg::*;
#(
    parameter int                ADDR_W      = MAP_ADDR_W,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pcInc;
    logic [ADDR_W-1:0] pcBr;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic [2:0]        sel;
    logic              stackFull;
    logic              stackEmpty;
    logic [ADDR_W-1:0] stackTop;
    logic [SP_W-1:0]   stackCount;

    // Both adds wrap naturally at ADDR_W; the offset is two's complement so no sign extension is needed
    assign pcInc = pc_q + ADDR_W'(1);
    assign pcBr  = pc_q + bus.offset;

    always_comb begin
        sel   = PCSEL_INC;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.stall) begin
            sel = PCSEL_HOLD;
        end else if (bus.ret_en) begin
            if (stackEmpty) unf_d = 1'b1;
            else            sel   = PCSEL_RET;
        end else if (bus.call_en) begin
            if (stackFull) ovf_d = 1'b1;
            else           sel   = PCSEL_CALL;
        end else if (bus.jump_en) begin
            sel = PCSEL_JMP;
        end else if (bus.branch_en) begin
            sel = PCSEL_BR;
        end
    end

    always_comb begin
        case (sel)
            PCSEL_HOLD: pc_d = pc_q;
            PCSEL_BR:   pc_d = pcBr;
            PCSEL_JMP:  pc_d = bus.target;
            PCSEL_CALL: pc_d = bus.target;
            PCSEL_RET:  pc_d = stackTop;
            default:    pc_d = pcInc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    pc_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (sel == PCSEL_CALL),
        .pop   (sel == PCSEL_RET),
        .din   (pcInc),
        .dout  (stackTop),
        .count (stackCount),
        .full  (stackFull),
        .empty (stackEmpty)
    );

    assign bus.pc        = pc_q;
    assign bus.sp        = stackCount;
    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;

endmodule
